// File: rtl/wb_scheduler.sv
// wb_scheduler: write-back port scheduler for the single register-file write port.
//
// Purpose
//   The scheduler arbitrates the write port between memory load returns (M) and ALU results (A).
//   An ALU result that loses arbitration is parked in an in-order deferral FIFO.
//   The ALU therefore only stalls when that FIFO is full.
//   A lookup port tells decode whether a register still has a write pending or in flight.
//
// Configuration
//   WB_RR_EN (macro) undefined : M has fixed priority and mem_ready is tied to 1.
//   WB_RR_EN (macro) defined   : contested grants alternate between M and A.
//                                The first contested grant after reset goes to M.
//
// Ports
//   clk, rst_n              clock (rising edge) and synchronous active-low reset
//   alu_valid/rd/data       ALU result offer; accepted when alu_valid && alu_ready
//   alu_ready               FIFO not full; derived from registered state only
//   mem_valid/rd/data       load return offer; accepted when mem_valid && mem_ready
//   mem_ready               1 unless M loses a contested round-robin grant
//   rf_we/waddr/wdata       registered register-file write
//   lookup_rd, lookup_hit   hazard query: hit when the register has a pending or in-flight write
//   fifo_count              deferral FIFO occupancy

module wb_scheduler #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alu_valid,
    input  logic [AW-1:0]          alu_rd,
    input  logic [DW-1:0]          alu_data,
    output logic                   alu_ready,
    input  logic                   mem_valid,
    input  logic [AW-1:0]          mem_rd,
    input  logic [DW-1:0]          mem_data,
    output logic                   mem_ready,
    output logic                   rf_we,
    output logic [AW-1:0]          rf_waddr,
    output logic [DW-1:0]          rf_wdata,
    input  logic [AW-1:0]          lookup_rd,
    output logic                   lookup_hit,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1'b1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);

    // FIFO state
    logic [AW-1:0]    fifo_rd_r   [DEPTH];
    logic [DW-1:0]    fifo_data_r [DEPTH];
    logic [DEPTH-1:0] fifo_vld_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [PW:0]      count_r;

    // Write-port output registers
    logic             rf_we_r;
    logic [AW-1:0]    rf_waddr_r;
    logic [DW-1:0]    rf_wdata_r;

    // Combinational control
    logic             fifo_empty_s;
    logic             a_cand_s;
    logic             grant_m_s;
    logic             grant_a_s;
    logic             mem_ready_s;
    logic             alu_ready_s;
    logic             direct_s;
    logic             enq_s;
    logic             deq_s;
    logic [AW-1:0]    win_rd_s;
    logic [DW-1:0]    win_data_s;
    logic             lookup_hit_s;

`ifdef WB_RR_EN
    logic             rr_r;        // 0: next contested grant goes to M
    logic             contested_s;
`endif

    assign fifo_empty_s = (count_r == {(PW+1){1'b0}});
    // A is represented by the FIFO head whenever the FIFO holds anything, else by the live ALU input.
    assign a_cand_s     = ~fifo_empty_s | alu_valid;
    assign alu_ready_s  = (count_r < CNT_FULL);

`ifdef WB_RR_EN
    assign contested_s  = mem_valid & a_cand_s;
`endif

    // Arbitration between the memory return and the ALU candidate
    always_comb begin
        grant_m_s   = mem_valid;
        grant_a_s   = a_cand_s & ~mem_valid;
        mem_ready_s = 1'b1;
`ifdef WB_RR_EN
        if (contested_s) begin
            grant_m_s   = ~rr_r;
            grant_a_s   = rr_r;
            mem_ready_s = ~rr_r;
        end else begin
            mem_ready_s = 1'b1;
        end
`endif
    end

    // A direct-path write bypasses the FIFO entirely; all other accepted ALU results are enqueued.
    assign direct_s = grant_a_s & fifo_empty_s;
    assign enq_s    = alu_valid & alu_ready_s & ~direct_s;
    assign deq_s    = grant_a_s & ~fifo_empty_s;

    // Winner selection for the write-port registers
    always_comb begin
        win_rd_s   = rf_waddr_r;
        win_data_s = rf_wdata_r;
        case ({grant_m_s, grant_a_s})
            2'b10: begin
                win_rd_s   = mem_rd;
                win_data_s = mem_data;
            end
            2'b01: begin
                if (fifo_empty_s) begin
                    win_rd_s   = alu_rd;
                    win_data_s = alu_data;
                end else begin
                    win_rd_s   = fifo_rd_r[rd_ptr_r];
                    win_data_s = fifo_data_r[rd_ptr_r];
                end
            end
            default: begin
                win_rd_s   = rf_waddr_r;
                win_data_s = rf_wdata_r;
            end
        endcase
    end

    // Hazard lookup over valid FIFO entries plus the write currently on the port
    always_comb begin
        lookup_hit_s = rf_we_r & (rf_waddr_r == lookup_rd);
        for (int i = 0; i < DEPTH; i++) begin
            lookup_hit_s = lookup_hit_s | (fifo_vld_r[i] & (fifo_rd_r[i] == lookup_rd));
        end
    end

    // FIFO pointers, occupancy and per-entry valid bits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_r   <= {PW{1'b0}};
            wr_ptr_r   <= {PW{1'b0}};
            count_r    <= {(PW+1){1'b0}};
            fifo_vld_r <= {DEPTH{1'b0}};
        end else begin
            if (enq_s) begin
                wr_ptr_r             <= wr_ptr_r + PTR_ONE;
                fifo_vld_r[wr_ptr_r] <= 1'b1;
            end
            // Dequeue and enqueue never target the same slot: that would need full and empty at once.
            if (deq_s) begin
                rd_ptr_r             <= rd_ptr_r + PTR_ONE;
                fifo_vld_r[rd_ptr_r] <= 1'b0;
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO payload storage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_rd_r[i]   <= {AW{1'b0}};
                fifo_data_r[i] <= {DW{1'b0}};
            end
        end else if (enq_s) begin
            fifo_rd_r[wr_ptr_r]   <= alu_rd;
            fifo_data_r[wr_ptr_r] <= alu_data;
        end
    end

    // Register-file write port; the address and data hold when there is no winner
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we_r    <= 1'b0;
            rf_waddr_r <= {AW{1'b0}};
            rf_wdata_r <= {DW{1'b0}};
        end else begin
            rf_we_r    <= grant_m_s | grant_a_s;
            rf_waddr_r <= win_rd_s;
            rf_wdata_r <= win_data_s;
        end
    end

`ifdef WB_RR_EN
    // Round-robin pointer; it flips only when both sources compete
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_r <= 1'b0;
        end else if (contested_s) begin
            rr_r <= ~rr_r;
        end else begin
            rr_r <= rr_r;
        end
    end
`endif

    assign alu_ready  = alu_ready_s;
    assign mem_ready  = mem_ready_s;
    assign rf_we      = rf_we_r;
    assign rf_waddr   = rf_waddr_r;
    assign rf_wdata   = rf_wdata_r;
    assign lookup_hit = lookup_hit_s;
    assign fifo_count = count_r;

endmodule

// File: tb/tb_wb_scheduler.sv
module tb_wb_scheduler;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alu_valid = 1'b0;
    logic [AW-1:0] alu_rd = '0;
    logic [DW-1:0] alu_data = '0;
    logic          alu_ready;
    logic          mem_valid = 1'b0;
    logic [AW-1:0] mem_rd = '0;
    logic [DW-1:0] mem_data = '0;
    logic          mem_ready;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] lookup_rd = '0;
    logic          lookup_hit;
    logic [2:0]    fifo_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, kept in terms of the specification: a queue of deferred
    // ALU results, the last write on the port, and the round-robin favour bit.
    logic [AW-1:0] q_rd[$];
    logic [DW-1:0] q_data[$];
    logic          m_we;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    bit            m_rr;

    wb_scheduler #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .lookup_rd(lookup_rd), .lookup_hit(lookup_hit), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    function automatic bit exp_mem_ready();
        bit contested;
        contested = mem_valid && ((q_rd.size() > 0) || alu_valid);
`ifdef WB_RR_EN
        return !(contested && m_rr);
`else
        return 1'b1;
`endif
    endfunction

    function automatic bit exp_hit(logic [AW-1:0] r);
        bit h;
        h = m_we && (m_waddr == r);
        foreach (q_rd[i]) if (q_rd[i] == r) h = 1'b1;
        return h;
    endfunction

    task automatic set_in(bit mv, logic [AW-1:0] mrd, logic [DW-1:0] md,
                          bit av, logic [AW-1:0] ard, logic [DW-1:0] ad);
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        alu_valid = av; alu_rd = ard; alu_data = ad;
    endtask

    // Advance the model by one cycle from the inputs as driven now, then let the DUT take the edge.
    task automatic tick();
        bit a_cand, contested, m_win, a_win, alu_acc, direct;
        int sz;
        sz = q_rd.size();
        if (!rst_n) begin
            q_rd.delete(); q_data.delete();
            m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_rr = 1'b0;
        end else begin
            a_cand    = (sz > 0) || alu_valid;
            contested = mem_valid && a_cand;
            m_win     = mem_valid;
            a_win     = a_cand && !mem_valid;
`ifdef WB_RR_EN
            if (contested) begin
                m_win = !m_rr; a_win = m_rr; m_rr = !m_rr;
            end
`endif
            alu_acc = alu_valid && (sz < DEPTH);
            direct  = a_win && (sz == 0);
            if (m_win) begin
                m_we = 1'b1; m_waddr = mem_rd; m_wdata = mem_data;
            end else if (a_win) begin
                m_we = 1'b1;
                if (sz > 0) begin
                    m_waddr = q_rd.pop_front(); m_wdata = q_data.pop_front();
                end else begin
                    m_waddr = alu_rd; m_wdata = alu_data;
                end
            end else begin
                m_we = 1'b0;
            end
            if (alu_acc && !direct) begin
                q_rd.push_back(alu_rd); q_data.push_back(alu_data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(1'b0, '0, '0, 1'b0, '0, '0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we got %0b want 0", rf_we); end
        n_checks++; if (rf_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_rf_waddr got %0d want 0", rf_waddr); end
        n_checks++; if (rf_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_rf_wdata got %h want 0", rf_wdata); end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", fifo_count); end
        n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_alu_ready got %0b want 1", alu_ready); end
        n_checks++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mem_ready got %0b want 1", mem_ready); end
    endtask

    task automatic test_direct();
        do_reset();
        set_in(1'b0, '0, '0, 1'b1, 5'd3, 32'h11);
        tick();
        set_in(1'b0, '0, '0, 1'b0, '0, '0);
        #1;
        n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL direct_we got %0b want 1", rf_we); end
        n_checks++; if (rf_waddr !== 5'd3) begin n_fail++; $display("FAIL direct_waddr got %0d want 3", rf_waddr); end
        n_checks++; if (rf_wdata !== 32'h11) begin n_fail++; $display("FAIL direct_wdata got %h want 11", rf_wdata); end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL direct_count got %0d want 0", fifo_count); end
        tick();
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL direct_we_drop got %0b want 0", rf_we); end
        n_checks++; if (rf_waddr !== 5'd3) begin n_fail++; $display("FAIL direct_hold got %0d want 3", rf_waddr); end
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            set_in(1'b1, 5'(20 + i), 32'hA000 + 32'(i), 1'b1, 5'(i), 32'h100 + 32'(i));
            #1;
            n_checks++; if (alu_ready !== (i <= 4)) begin n_fail++; $display("FAIL fill_alu_ready cyc %0d got %0b want %0b", i, alu_ready, (i <= 4)); end
            tick();
            n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'(20 + i) || rf_wdata !== 32'hA000 + 32'(i)) begin
                n_fail++; $display("FAIL fill_mem_write cyc %0d got we=%0b rd=%0d data=%h want we=1 rd=%0d", i, rf_we, rf_waddr, rf_wdata, 20 + i);
            end
        end
        set_in(1'b0, '0, '0, 1'b0, '0, '0);
        #1;
        n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL fill_count got %0d want 4", fifo_count); end
        for (int k = 1; k <= 4; k++) begin
            n_checks++; if (alu_ready !== (k != 1)) begin n_fail++; $display("FAIL drain_alu_ready step %0d got %0b want %0b", k, alu_ready, (k != 1)); end
            tick();
            n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'(k) || rf_wdata !== 32'h100 + 32'(k)) begin
                n_fail++; $display("FAIL drain_order step %0d got we=%0b rd=%0d data=%h want rd=%0d", k, rf_we, rf_waddr, rf_wdata, k);
            end
        end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL drain_count got %0d want 0", fifo_count); end
    endtask

    task automatic test_lookup();
        do_reset();
        set_in(1'b1, 5'd9, 32'h9, 1'b1, 5'd7, 32'h77);
        tick();
        set_in(1'b0, '0, '0, 1'b0, '0, '0);
        lookup_rd = 5'd7; #1;
        n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL lookup_count got %0d want 1", fifo_count); end
        n_checks++; if (lookup_hit !== 1'b1) begin n_fail++; $display("FAIL lookup_fifo_hit got %0b want 1", lookup_hit); end
        lookup_rd = 5'd8; #1;
        n_checks++; if (lookup_hit !== 1'b0) begin n_fail++; $display("FAIL lookup_miss got %0b want 0", lookup_hit); end
        lookup_rd = 5'd7;
        tick();
        n_checks++; if (rf_waddr !== 5'd7 || rf_we !== 1'b1) begin n_fail++; $display("FAIL lookup_write got we=%0b rd=%0d want we=1 rd=7", rf_we, rf_waddr); end
        n_checks++; if (lookup_hit !== 1'b1) begin n_fail++; $display("FAIL lookup_inflight got %0b want 1", lookup_hit); end
        tick();
        n_checks++; if (lookup_hit !== 1'b0) begin n_fail++; $display("FAIL lookup_retired got %0b want 0", lookup_hit); end
    endtask

`ifdef WB_RR_EN
    task automatic test_rr();
        logic [AW-1:0] want_rd [4];
        bit            want_mr [4];
        want_rd[0] = 5'd10; want_rd[1] = 5'd1; want_rd[2] = 5'd12; want_rd[3] = 5'd2;
        want_mr[0] = 1'b1;  want_mr[1] = 1'b0; want_mr[2] = 1'b1;  want_mr[3] = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 5'(10 + i), 32'(10 + i), 1'b1, 5'(1 + i), 32'(1 + i));
            #1;
            n_checks++; if (mem_ready !== want_mr[i]) begin n_fail++; $display("FAIL rr_mem_ready cyc %0d got %0b want %0b", i + 1, mem_ready, want_mr[i]); end
            tick();
            n_checks++; if (rf_waddr !== want_rd[i]) begin n_fail++; $display("FAIL rr_order cyc %0d got %0d want %0d", i + 1, rf_waddr, want_rd[i]); end
        end
        set_in(1'b0, '0, '0, 1'b0, '0, '0);
    endtask
`endif

    task automatic test_reset_midflight();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            set_in(1'b1, 5'd20, 32'h20, 1'b1, 5'(i), 32'(i));
            tick();
        end
        set_in(1'b0, '0, '0, 1'b0, '0, '0);
        #1;
        n_checks++; if (fifo_count !== 3'(q_rd.size())) begin n_fail++; $display("FAIL mid_count got %0d want %0d", fifo_count, q_rd.size()); end
        rst_n = 1'b0;
        tick();
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL mid_reset_count got %0d want 0", fifo_count); end
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL mid_reset_we got %0b want 0", rf_we); end
        n_checks++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_alu_ready got %0b want 1", alu_ready); end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL mid_stale_write cyc %0d got we=%0b rd=%0d", i, rf_we, rf_waddr); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            set_in($urandom_range(0, 99) < 45, 5'($urandom_range(0, 7)), $urandom,
                   $urandom_range(0, 99) < 65, 5'($urandom_range(0, 7)), $urandom);
            lookup_rd = 5'($urandom_range(0, 7));
            rst_n = ($urandom_range(0, 99) != 0);
            #1;
            n_checks++; if (alu_ready !== (q_rd.size() < DEPTH)) begin n_fail++; $display("FAIL rand_alu_ready cyc %0d got %0b want %0b", c, alu_ready, (q_rd.size() < DEPTH)); end
            n_checks++; if (mem_ready !== exp_mem_ready()) begin n_fail++; $display("FAIL rand_mem_ready cyc %0d got %0b want %0b", c, mem_ready, exp_mem_ready()); end
            n_checks++; if (fifo_count !== 3'(q_rd.size())) begin n_fail++; $display("FAIL rand_count cyc %0d got %0d want %0d", c, fifo_count, q_rd.size()); end
            n_checks++; if (lookup_hit !== exp_hit(lookup_rd)) begin n_fail++; $display("FAIL rand_lookup cyc %0d rd %0d got %0b want %0b", c, lookup_rd, lookup_hit, exp_hit(lookup_rd)); end
            tick();
            n_checks++; if (rf_we !== m_we || rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
                n_fail++; $display("FAIL rand_write cyc %0d got we=%0b rd=%0d data=%h want we=%0b rd=%0d data=%h", c, rf_we, rf_waddr, rf_wdata, m_we, m_waddr, m_wdata);
            end
        end
        rst_n = 1'b1;
        set_in(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        test_reset();
        test_direct();
`ifdef WB_RR_EN
        test_rr();
`else
        test_fill_drain();
`endif
        test_lookup();
        test_reset_midflight();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_scheduler.md
# wb_scheduler

Write-back port scheduler for the pipeline's single register-file write port. It accepts ALU results (fixed latency) and memory load returns (variable latency) and arbitrates the port between them. ALU results that lose arbitration are held in a small in-order FIFO so the ALU stage only stalls when that FIFO fills. It also reports whether a register has a write still in flight, for hazard detection in decode.

## Interface
- DEPTH, 4, ALU deferral FIFO entries; power of 2, ≥2
- AW, 5, register address width
- DW, 32, data width
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- alu_valid  in  1  ALU result offered this cycle
- alu_rd  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- alu_ready  out  1  ALU result accepted when alu_valid && alu_ready
- mem_valid  in  1  load data offered this cycle
- mem_rd  in  AW  load destination register
- mem_data  in  DW  load data
- mem_ready  out  1  load accepted when mem_valid && mem_ready
- rf_we  out  1  register-file write enable, registered
- rf_waddr  out  AW  write address, registered
- rf_wdata  out  DW  write data, registered
- lookup_rd  in  AW  register queried by decode
- lookup_hit  out  1  lookup_rd has a pending or in-flight write
- fifo_count  out  log2(DEPTH)+1  FIFO occupancy

## Operation
- The scheduler grants at most one write per cycle. The grant candidates are:
  - M: mem_valid.
  - A: FIFO head when the FIFO is non-empty; otherwise the direct ALU path (alu_valid).
- Direct path: if the FIFO is empty and A wins, the ALU result goes straight to the rf_* registers with no enqueue.
- ALU acceptance when the direct path does not win:
  - alu_valid && alu_ready enqueues at the tail.
  - This happens on the same cycle the head dequeues, when it does.
- FIFO order: ALU writes retire in issue order. M vs A ordering is not tracked; decode uses lookup_hit to avoid WAW/RAW hazards.
- alu_ready = (fifo_count < DEPTH). It is computed from registered state only, so a dequeue in the same cycle does not raise it.
- Arbitration, default: M has fixed priority and mem_ready = 1 always. A is granted only when mem_valid = 0.
- Winner capture: the winner's rd/data are registered into rf_waddr/rf_wdata with rf_we = 1 on the next edge. With no winner, rf_we = 0 and rf_waddr/rf_wdata hold.
- lookup_hit (combinational) = 1 when lookup_rd equals either:
  - the rd of any valid FIFO entry, or
  - rf_waddr while rf_we = 1.
- Not included in lookup_hit: same-cycle alu_rd and mem_rd inputs.
- Register 0 gets no special treatment.

## Timing
- Reset (rst_n = 0 at a rising edge):
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0.
  - FIFO empty, fifo_count = 0, alu_ready = 1, mem_ready = 1.
  - Round-robin pointer favours M.
  - In-flight entries are discarded.
- Latency:
  - Granted input at edge N appears on rf_* during cycle N+1, for exactly one cycle per write.
  - ALU result enqueued at depth k (0 = head) is written no earlier than k+1 cycles after it becomes head-eligible.
- FIFO full: alu_ready = 0 and ALU input is ignored. alu_ready rises the cycle after the first dequeue.
- FIFO empty while M is granted and alu_valid = 1: the result enqueues and fifo_count becomes 1.
- Pointer wrap: read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH. fifo_count is one bit wider to distinguish full from empty.
- Simultaneous enqueue and dequeue: fifo_count unchanged.

## Configuration
- WB_RR_EN defined:
  - When M and A are both valid, the grant alternates, starting with M after reset.
  - The pointer flips only on a contested grant.
  - mem_ready = 0 in cycles where M loses; it is combinational from mem_valid, FIFO state and the pointer.
- WB_RR_EN undefined: fixed M priority, mem_ready tied to 1, no pointer flop.

## Test plan
- Reset, then alu_valid = 1, rd = 3, data = 0x11 for one cycle → next cycle rf_we = 1, rf_waddr = 3, rf_wdata = 0x11; fifo_count stays 0.
- mem_valid and alu_valid held high for 6 cycles, ALU rd = 1..6 (default config) → mem writes every cycle, FIFO fills to 4, alu_ready = 0 from cycle 5; ALU rd 5 and 6 are not accepted.
- Then drop mem_valid → FIFO drains rd 1, 2, 3, 4 in order over 4 cycles; fifo_count = 0; alu_ready back to 1 the cycle after the first dequeue.
- FIFO holding rd 7 → lookup_rd = 7 gives lookup_hit = 1, lookup_rd = 8 gives 0. The cycle after rd 7 is written, lookup_hit remains 1, then drops to 0.
- WB_RR_EN defined, both sources valid for 4 cycles → rf_waddr sequence M, A, M, A; mem_ready = 0 on cycles 2 and 4.
- Reset asserted with FIFO at 3 entries → next cycle fifo_count = 0, rf_we = 0, alu_ready = 1, and no stale writes after release.
